// File: rtl/add_pipe_lanes.sv
// Multi-lane pipelined adder with valid/ready handshakes on both sides.
// Each lane can be signed or unsigned and can wrap or saturate; a tag rides along with each transaction.
module add_pipe_lanes #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_LANES   = 4,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_WIDTH   = 4,
    parameter int SIGNED      = 0,
    parameter int SATURATE    = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] in_a,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] in_b,
    input  logic [TAG_WIDTH-1:0]            in_tag,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_LANES*DATA_WIDTH-1:0] out_sum,
    output logic [NUM_LANES-1:0]            out_ovf,
    output logic [TAG_WIDTH-1:0]            out_tag,
    output logic [15:0]                     txn_count
);

    localparam int VW   = NUM_LANES * DATA_WIDTH;
    localparam int LAST = PIPE_STAGES - 1;

    localparam logic [DATA_WIDTH-1:0] POS_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] NEG_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;

    logic [VW-1:0]         lane_sum;
    logic [NUM_LANES-1:0]  lane_ovf;
    logic [DATA_WIDTH-1:0] lane_a;
    logic [DATA_WIDTH-1:0] lane_b;
    logic [DATA_WIDTH:0]   lane_wide;
    logic [DATA_WIDTH-1:0] lane_res;
    logic                  lane_flag;

    logic [PIPE_STAGES-1:0] v_q;
    logic [PIPE_STAGES-1:0] v_d;
    logic [PIPE_STAGES-1:0] load;
    logic [VW-1:0]          sum_q [PIPE_STAGES];
    logic [VW-1:0]          sum_d [PIPE_STAGES];
    logic [NUM_LANES-1:0]   ovf_q [PIPE_STAGES];
    logic [NUM_LANES-1:0]   ovf_d [PIPE_STAGES];
    logic [TAG_WIDTH-1:0]   tag_q [PIPE_STAGES];
    logic [TAG_WIDTH-1:0]   tag_d [PIPE_STAGES];
    logic [15:0]            txn_count_q;
    logic [15:0]            txn_count_d;
    logic                   accept;

    // Each lane uses a one-bit-wider sum; the extra bit is the unsigned carry.
    always_comb begin
        lane_sum  = '0;
        lane_ovf  = '0;
        lane_a    = '0;
        lane_b    = '0;
        lane_wide = '0;
        lane_res  = '0;
        lane_flag = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_a    = in_a[i*DATA_WIDTH +: DATA_WIDTH];
            lane_b    = in_b[i*DATA_WIDTH +: DATA_WIDTH];
            lane_wide = {1'b0, lane_a} + {1'b0, lane_b};
            lane_res  = lane_wide[DATA_WIDTH-1:0];
            if (SIGNED != 0) begin
                lane_flag = (lane_a[DATA_WIDTH-1] == lane_b[DATA_WIDTH-1]) &&
                            (lane_wide[DATA_WIDTH-1] != lane_a[DATA_WIDTH-1]);
                if ((SATURATE != 0) && lane_flag) begin
                    lane_res = lane_a[DATA_WIDTH-1] ? NEG_MIN : POS_MAX;
                end
            end else begin
                lane_flag = lane_wide[DATA_WIDTH];
                if ((SATURATE != 0) && lane_flag) begin
                    lane_res = ALL_ONES;
                end
            end
            lane_sum[i*DATA_WIDTH +: DATA_WIDTH] = lane_res;
            lane_ovf[i] = lane_flag;
        end
    end

    // Load enables ripple backwards from out_ready, so a full pipe still moves at full rate.
    always_comb begin
        load = '0;
        load[LAST] = !v_q[LAST] || out_ready;
        for (int k = LAST - 1; k >= 0; k--) begin
            load[k] = !v_q[k] || load[k+1];
        end
        in_ready = !rst && load[0];
        accept   = in_valid && in_ready;

        v_d   = v_q;
        sum_d = sum_q;
        ovf_d = ovf_q;
        tag_d = tag_q;

        if (load[0]) begin
            v_d[0] = accept;
            if (accept) begin
                sum_d[0] = lane_sum;
                ovf_d[0] = lane_ovf;
                tag_d[0] = in_tag;
            end
        end
        for (int k = 1; k < PIPE_STAGES; k++) begin
            if (load[k]) begin
                v_d[k] = v_q[k-1];
                if (v_q[k-1]) begin
                    sum_d[k] = sum_q[k-1];
                    ovf_d[k] = ovf_q[k-1];
                    tag_d[k] = tag_q[k-1];
                end
            end
        end

        txn_count_d = txn_count_q + {15'd0, (v_q[LAST] && out_ready)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q         <= '0;
            txn_count_q <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                sum_q[k] <= '0;
                ovf_q[k] <= '0;
                tag_q[k] <= '0;
            end
        end else begin
            v_q         <= v_d;
            txn_count_q <= txn_count_d;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                sum_q[k] <= sum_d[k];
                ovf_q[k] <= ovf_d[k];
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign out_valid = v_q[LAST];
    assign out_sum   = sum_q[LAST];
    assign out_ovf   = ovf_q[LAST];
    assign out_tag   = tag_q[LAST];
    assign txn_count = txn_count_q;

endmodule

// File: tb/tb_add_pipe_lanes.sv
// Directed bench for add_pipe_lanes: three instances share the inputs and differ only in
// signed/saturate mode so the arithmetic modes are compared against the same stimulus.
module tb_add_pipe_lanes;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_tag;
    logic        out_ready;

    logic        in_ready,  in_ready_us,  in_ready_ss;
    logic        out_valid, out_valid_us, out_valid_ss;
    logic [31:0] out_sum,   out_sum_us,   out_sum_ss;
    logic [3:0]  out_ovf,   out_ovf_us,   out_ovf_ss;
    logic [3:0]  out_tag,   out_tag_us,   out_tag_ss;
    logic [15:0] txn_count, txn_count_us, txn_count_ss;

    int checkCount;
    int errorCount;

    add_pipe_lanes #(.SIGNED(0), .SATURATE(0)) dut_uw (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_ovf(out_ovf), .out_tag(out_tag), .txn_count(txn_count)
    );

    add_pipe_lanes #(.SIGNED(0), .SATURATE(1)) dut_us (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_us),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid_us), .out_ready(out_ready), .out_sum(out_sum_us),
        .out_ovf(out_ovf_us), .out_tag(out_tag_us), .txn_count(txn_count_us)
    );

    add_pipe_lanes #(.SIGNED(1), .SATURATE(1)) dut_ss (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_ss),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid_ss), .out_ready(out_ready), .out_sum(out_sum_ss),
        .out_ovf(out_ovf_ss), .out_tag(out_tag_ss), .txn_count(txn_count_ss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives one transaction and returns at the falling edge just after it was accepted.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        int waitCycles;
        @(negedge clk);
        in_a = a;
        in_b = b;
        in_tag = tag;
        in_valid = 1'b1;
        #1;
        waitCycles = 0;
        while (!in_ready && waitCycles < 20) begin
            @(negedge clk);
            #1;
            waitCycles++;
        end
        if (!in_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic runVector(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                             input logic [31:0] expUw, input logic [3:0] ovfUw,
                             input logic [31:0] expUs, input logic [3:0] ovfUs,
                             input logic [31:0] expSs, input logic [3:0] ovfSs);
        out_ready = 1'b1;
        applyStimulus(a, b, tag);
        checkOutput("latency_not_early", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        checkOutput("latency_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("sum_uw", out_sum, expUw);
        checkOutput("ovf_uw", {28'd0, out_ovf}, {28'd0, ovfUw});
        checkOutput("tag", {28'd0, out_tag}, {28'd0, tag});
        checkOutput("sum_us", out_sum_us, expUs);
        checkOutput("ovf_us", {28'd0, out_ovf_us}, {28'd0, ovfUs});
        checkOutput("sum_ss", out_sum_ss, expSs);
        checkOutput("ovf_ss", {28'd0, out_ovf_ss}, {28'd0, ovfSs});
        @(negedge clk);
        checkOutput("no_duplicate", {31'd0, out_valid}, 32'd0);
    endtask

    // Streams n transactions (lane data = index, b = 0x10), optionally stalling the output first.
    task automatic streamTxns(input int n, input int stall, input bit expectFull);
        int sent;
        int rcvd;
        int cyc;
        logic [7:0] idx;
        logic [7:0] laneExp;
        sent = 0;
        rcvd = 0;
        cyc = 0;
        while (rcvd < n && cyc < n * 4 + 50) begin
            @(negedge clk);
            out_ready = (cyc >= stall);
            idx = sent[7:0];
            if (sent < n) begin
                in_valid = 1'b1;
                in_a = {4{idx}};
                in_b = {4{8'h10}};
                in_tag = idx[3:0];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stall > 0 && cyc == stall - 1) begin
                checkOutput("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
                checkOutput("bp_accepts", sent, 2);
            end
            if (stall > 0 && cyc >= 2 && cyc < stall) begin
                checkOutput("bp_hold_valid", {31'd0, out_valid}, 32'd1);
                checkOutput("bp_hold_tag", {28'd0, out_tag}, 32'd0);
                checkOutput("bp_hold_sum", out_sum, {4{8'h10}});
            end
            if (expectFull && sent < n) checkOutput("fr_in_ready", {31'd0, in_ready}, 32'd1);
            if (out_valid && out_ready) begin
                idx = rcvd[7:0];
                laneExp = idx + 8'h10;
                checkOutput("stream_tag", {28'd0, out_tag}, {28'd0, idx[3:0]});
                checkOutput("stream_sum", out_sum, {4{laneExp}});
                rcvd++;
            end
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        checkOutput("stream_count", rcvd, n);
        @(negedge clk);
        @(negedge clk);
        checkOutput("stream_no_extra", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic streamCount(input int n);
        int sent;
        int cyc;
        sent = 0;
        cyc = 0;
        out_ready = 1'b1;
        in_a = '0;
        in_b = '0;
        in_tag = '0;
        while (sent < n && cyc < n + 20) begin
            @(negedge clk);
            in_valid = 1'b1;
            #1;
            if (in_ready) sent++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("count_accepts", sent, n);
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst = 1'b1;
        in_valid = 1'b1;
        in_a = '0;
        in_b = '0;
        in_tag = '0;
        out_ready = 1'b1;

        #12;
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_out_sum", out_sum, 32'd0);
        checkOutput("reset_out_ovf", {28'd0, out_ovf}, 32'd0);
        checkOutput("reset_out_tag", {28'd0, out_tag}, 32'd0);
        checkOutput("reset_txn_count", {16'd0, txn_count}, 32'd0);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;

        $display("[TB] single transaction, mixed carries");
        runVector(32'h80FF7F01, 32'h80010102, 4'h5,
                  32'h00008003, 4'b1100,
                  32'hFFFF8003, 4'b1100,
                  32'h80007F03, 4'b1010);
        checkOutput("txn_count_one", {16'd0, txn_count}, 32'd1);

        $display("[TB] unsigned overflow in every lane");
        runVector(32'hF0F0F0F0, 32'h20202020, 4'h6,
                  32'h10101010, 4'b1111,
                  32'hFFFFFFFF, 4'b1111,
                  32'h10101010, 4'b0000);

        $display("[TB] signed overflow cases");
        runVector(32'h0040807F, 32'h00C0FF01, 4'h7,
                  32'h00007F80, 4'b0110,
                  32'h00FFFF80, 4'b0110,
                  32'h0000807F, 4'b0011);

        $display("[TB] backpressure stall");
        resetDut();
        streamTxns(10, 6, 1'b0);
        checkOutput("bp_txn_count", {16'd0, txn_count}, 32'd10);

        $display("[TB] full-rate stream");
        streamTxns(100, 0, 1'b1);
        checkOutput("fr_txn_count", {16'd0, txn_count}, 32'd110);

        $display("[TB] asynchronous reset mid-flight");
        out_ready = 1'b0;
        applyStimulus(32'h01010101, 32'h01010101, 4'h1);
        applyStimulus(32'h02020202, 32'h02020202, 4'h2);
        #2;
        in_valid = 1'b1;
        rst = 1'b1;
        #1;
        checkOutput("arst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("arst_txn_count", {16'd0, txn_count}, 32'd0);
        checkOutput("arst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("arst_out_sum", out_sum, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("arst_no_stale", {31'd0, out_valid}, 32'd0);
        runVector(32'h11223344, 32'h01010101, 4'h9,
                  32'h12233445, 4'b0000,
                  32'h12233445, 4'b0000,
                  32'h12233445, 4'b0000);
        checkOutput("arst_txn_count_after", {16'd0, txn_count}, 32'd1);

        $display("[TB] txn_count wrap");
        resetDut();
        streamCount(65535);
        checkOutput("wrap_ffff", {16'd0, txn_count}, 32'h0000FFFF);
        streamCount(1);
        checkOutput("wrap_zero", {16'd0, txn_count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
